// File: rtl/load_store_unit.sv
// Load/store initiator for the word-addressed data memory: lane extraction, sign/zero
// extension, and (with LSU_RMW_EN defined) SB/SH via read-modify-write.
module load_store_unit #(
  parameter int Width       = 32,
  parameter int AddrWidth   = 9,
  parameter int MEM_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_funct3,
  input  logic [Width-1:0] req_addr,
  input  logic [Width-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [Width-1:0] rsp_rdata,
  output logic             rsp_error,
  output logic             MemTrig,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [Width-1:0] address,
  output logic [Width-1:0] WriteData,
  input  logic [Width-1:0] ReadData
);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(MEM_LATENCY - 1);
`ifdef LSU_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic                 write_q, write_d;
  logic [2:0]           f3_q, f3_d;
  logic [AddrWidth-1:0] widx_q, widx_d;
  logic [1:0]           lane_q, lane_d;
  logic [Width-1:0]     wdata_q, wdata_d;
  logic [Width-1:0]     rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 req_err;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [Width-1:0]     ld_ext;

  // Address bits above the word index are deliberately dropped (wrap-around).
  logic unused_ok;
`ifdef LSU_RMW_EN
  assign unused_ok = ^req_addr[Width-1:AddrWidth+2];
`else
  assign unused_ok = ^{req_addr[Width-1:AddrWidth+2], write_q};
`endif

  always_comb begin
    req_err = 1'b0;
    if (req_write) begin
      case (req_funct3)
        3'b000:  req_err = !RMW;
        3'b001:  req_err = !RMW || req_addr[0];
        3'b010:  req_err = (req_addr[1:0] != 2'b00);
        default: req_err = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b100: req_err = 1'b0;
        3'b001, 3'b101: req_err = req_addr[0];
        3'b010:         req_err = (req_addr[1:0] != 2'b00);
        default:        req_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    ld_byte = ReadData[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? ReadData[16 +: 16] : ReadData[0 +: 16];
    case (f3_q[1:0])
      2'b00:   ld_ext = {{(Width-8){ld_byte[7] & ~f3_q[2]}}, ld_byte};
      2'b01:   ld_ext = {{(Width-16){ld_half[15] & ~f3_q[2]}}, ld_half};
      default: ld_ext = ReadData;
    endcase
  end

`ifdef LSU_RMW_EN
  logic [Width-1:0] merged;
  always_comb begin
    merged = ReadData;
    if (f3_q[0]) merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else         merged[{lane_q, 3'b000} +: 8]      = wdata_q[7:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      f3_q    <= '0;
      widx_q  <= '0;
      lane_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      f3_q    <= f3_d;
      widx_q  <= widx_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    f3_d    = f3_q;
    widx_d  = widx_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        write_d = req_write;
        f3_d    = req_funct3;
        widx_d  = req_addr[AddrWidth+1:2];
        lane_d  = req_addr[1:0];
        wdata_d = req_write ? req_wdata : '0;
        err_d   = req_err;
        if (req_err) begin
          rdata_d = '0;
          state_d = RESP;
        end else if (req_write && req_funct3 == 3'b010) begin
          state_d = WR_ISSUE;
        end else begin
          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: if (cnt_q == LAT_LAST) begin
`ifdef LSU_RMW_EN
        if (write_q) begin
          wdata_d = merged;
          state_d = WR_ISSUE;
        end else
`endif
        begin
          rdata_d = ld_ext;
          state_d = RESP;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      WR_ISSUE: begin
        cnt_d   = '0;
        state_d = WR_WAIT;
      end
      WR_WAIT: if (cnt_q == LAT_LAST) begin
        rdata_d = '0;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_error = (state_q == RESP) && err_q;
    rsp_rdata = rdata_q;
    MemRead   = (state_q == RD_ISSUE);
    MemWrite  = (state_q == WR_ISSUE);
    MemTrig   = MemRead || MemWrite;
    address   = (state_q == IDLE) ? '0 : {{(Width-AddrWidth){1'b0}}, widx_q};
    WriteData = wdata_q;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: two LSU instances (latency 1 and 3) share stimulus, each with its own memory.
`timescale 1ns/1ps
module tb_load_store_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready [2], rsp_valid [2], rsp_error [2];
  logic        mtrig [2], mread [2], mwrite [2];
  logic [31:0] rsp_rdata [2], address [2], wdata [2], rdata [2];
  logic [31:0] mem [2][512];

  load_store_unit #(.Width(32), .AddrWidth(9), .MEM_LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]),
    .MemTrig(mtrig[0]), .MemRead(mread[0]), .MemWrite(mwrite[0]),
    .address(address[0]), .WriteData(wdata[0]), .ReadData(rdata[0]));

  load_store_unit #(.Width(32), .AddrWidth(9), .MEM_LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]),
    .MemTrig(mtrig[1]), .MemRead(mread[1]), .MemWrite(mwrite[1]),
    .address(address[1]), .WriteData(wdata[1]), .ReadData(rdata[1]));

  // Memory model: read data registered off the strobe edge and held until the next read.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        for (int j = 0; j < 512; j++) mem[i][j] <= 32'h5A5A0000 | j;
        mem[i][0] <= 32'hCAFEF00D;
        mem[i][3] <= 32'h80FF7F01;
        mem[i][4] <= 32'h11223344;
      end else begin
        if (mtrig[i] && mread[i])  rdata[i] <= mem[i][address[i][8:0]];
        if (mtrig[i] && mwrite[i]) mem[i][address[i][8:0]] <= wdata[i];
      end
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // kind: 0 error, 1 load, 2 SW, 3 read-modify-write store
  typedef struct {
    bit        wr;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wd;
    int        kind;
    bit [31:0] exp_rd;
    bit [31:0] exp_word;
    bit [31:0] exp_wd;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int rsp_cyc [2], rd_cyc [2], wr_cyc [2], ntrig [2], nrsp [2];
    logic [31:0] got_rd [2], got_addr [2], got_wd [2];
    logic got_err [2];
    int lat, exp_rsp, exp_rdc, exp_wrc, exp_trig;
    for (int i = 0; i < 2; i++) begin
      rsp_cyc[i] = -1; rd_cyc[i] = -1; wr_cyc[i] = -1; ntrig[i] = 0; nrsp[i] = 0;
      got_rd[i] = 'x; got_addr[i] = 'x; got_wd[i] = 'x; got_err[i] = 1'bx;
    end
    @(negedge clk);
    chk($sformatf("v%0d ready", idx), {31'b0, req_ready[0] & req_ready[1]}, 32'd1);
    req_write = v.wr; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wd; req_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (mtrig[i]) begin
          ntrig[i]++;
          got_addr[i] = address[i];
        end
        if (mtrig[i] && mread[i] && rd_cyc[i] < 0) rd_cyc[i] = c;
        if (mtrig[i] && mwrite[i]) begin
          wr_cyc[i] = c;
          got_wd[i] = wdata[i];
        end
        if (rsp_valid[i]) begin
          nrsp[i]++;
          rsp_cyc[i] = c;
          got_rd[i] = rsp_rdata[i];
          got_err[i] = rsp_error[i];
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? 1 : 3;
      exp_rsp  = (v.kind == 0) ? 1 : (v.kind == 3) ? 2 * lat + 3 : lat + 2;
      exp_rdc  = (v.kind == 1 || v.kind == 3) ? 1 : -1;
      exp_wrc  = (v.kind == 2) ? 1 : (v.kind == 3) ? lat + 2 : -1;
      exp_trig = (v.kind == 0) ? 0 : (v.kind == 3) ? 2 : 1;
      chk($sformatf("v%0d L%0d rsp_cycle", idx, lat), 32'(rsp_cyc[i]), 32'(exp_rsp));
      chk($sformatf("v%0d L%0d rsp_count", idx, lat), 32'(nrsp[i]), 32'd1);
      chk($sformatf("v%0d L%0d rsp_error", idx, lat), {31'b0, got_err[i]}, {31'b0, v.kind == 0});
      chk($sformatf("v%0d L%0d strobes", idx, lat), 32'(ntrig[i]), 32'(exp_trig));
      chk($sformatf("v%0d L%0d rd_cycle", idx, lat), 32'(rd_cyc[i]), 32'(exp_rdc));
      chk($sformatf("v%0d L%0d wr_cycle", idx, lat), 32'(wr_cyc[i]), 32'(exp_wrc));
      if (v.kind != 0) begin
        chk($sformatf("v%0d L%0d rdata", idx, lat), got_rd[i], v.exp_rd);
        chk($sformatf("v%0d L%0d address", idx, lat), got_addr[i], v.exp_word);
      end
      if (v.kind >= 2) chk($sformatf("v%0d L%0d WriteData", idx, lat), got_wd[i], v.exp_wd);
    end
  endtask

  vec_t vq[$];
  int   n_trig, n_wr, n_rsp;

  initial begin
    vq.push_back('{1'b0, 3'd2, 32'h0C, 32'h0, 1, 32'h80FF7F01, 32'd3, 32'h0});  // LW
    vq.push_back('{1'b0, 3'd0, 32'h0F, 32'h0, 1, 32'hFFFFFF80, 32'd3, 32'h0});  // LB
    vq.push_back('{1'b0, 3'd4, 32'h0F, 32'h0, 1, 32'h00000080, 32'd3, 32'h0});  // LBU
    vq.push_back('{1'b0, 3'd1, 32'h0E, 32'h0, 1, 32'hFFFF80FF, 32'd3, 32'h0});  // LH
    vq.push_back('{1'b0, 3'd5, 32'h0C, 32'h0, 1, 32'h00007F01, 32'd3, 32'h0});  // LHU
    vq.push_back('{1'b0, 3'd0, 32'h0D, 32'h0, 1, 32'h0000007F, 32'd3, 32'h0});  // LB +ve
    vq.push_back('{1'b0, 3'd2, 32'h0E, 32'h0, 0, 32'h0, 32'd0, 32'h0});         // LW misaligned
    vq.push_back('{1'b0, 3'd3, 32'h00, 32'h0, 0, 32'h0, 32'd0, 32'h0});         // illegal load
    vq.push_back('{1'b0, 3'd5, 32'h0D, 32'h0, 0, 32'h0, 32'd0, 32'h0});         // LHU odd
    vq.push_back('{1'b1, 3'd4, 32'h0C, 32'h1, 0, 32'h0, 32'd0, 32'h0});         // store 1xx
`ifdef LSU_RMW_EN
    vq.push_back('{1'b1, 3'd0, 32'h0D, 32'h123456AA, 3, 32'h0, 32'd3, 32'h80FFAA01});
    vq.push_back('{1'b0, 3'd2, 32'h0C, 32'h0, 1, 32'h80FFAA01, 32'd3, 32'h0});
    vq.push_back('{1'b1, 3'd1, 32'h10, 32'h0000BEEF, 3, 32'h0, 32'd4, 32'h1122BEEF});
    vq.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 1, 32'h1122BEEF, 32'd4, 32'h0});
    vq.push_back('{1'b1, 3'd1, 32'h11, 32'h0000BEEF, 0, 32'h0, 32'd0, 32'h0}); // SH odd
`else
    vq.push_back('{1'b1, 3'd0, 32'h0D, 32'h123456AA, 0, 32'h0, 32'd0, 32'h0});
    vq.push_back('{1'b0, 3'd2, 32'h0C, 32'h0, 1, 32'h80FF7F01, 32'd3, 32'h0});
    vq.push_back('{1'b1, 3'd1, 32'h10, 32'h0000BEEF, 0, 32'h0, 32'd0, 32'h0});
    vq.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 1, 32'h11223344, 32'd4, 32'h0});
`endif
    vq.push_back('{1'b1, 3'd2, 32'h7FC, 32'hDEADBEEF, 2, 32'h0, 32'd511, 32'hDEADBEEF});
    vq.push_back('{1'b0, 3'd2, 32'h7FC, 32'h0, 1, 32'hDEADBEEF, 32'd511, 32'h0});
    vq.push_back('{1'b0, 3'd2, 32'h800, 32'h0, 1, 32'hCAFEF00D, 32'd0, 32'h0});  // wraps

    // Reset state
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset ready %0d", i), {31'b0, req_ready[i]}, 32'd1);
      chk($sformatf("reset out %0d", i),
          {26'b0, rsp_valid[i], rsp_error[i], mtrig[i], mread[i], mwrite[i], 1'b0}, 32'd0);
      chk($sformatf("reset rdata %0d", i), rsp_rdata[i], 32'd0);
      chk($sformatf("reset addr %0d", i), address[i], 32'd0);
      chk($sformatf("reset wdata %0d", i), wdata[i], 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vq[k]) run_vec(vq[k], k);

    // Async reset while the read strobe is up: strobes drop without waiting for an edge.
    @(negedge clk);
    req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0C; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("arst strobe before", {31'b0, mtrig[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst strobe after", {30'b0, mtrig[0], mtrig[1]}, 32'd0);
    chk("arst ready", {30'b0, req_ready[0], req_ready[1]}, 32'd3);
    chk("arst address", address[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_trig = 0; n_rsp = 0;
    repeat (10) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (mtrig[i]) n_trig++;
        if (rsp_valid[i]) n_rsp++;
      end
    end
    chk("arst no strobe", 32'(n_trig), 32'd0);
    chk("arst no rsp", 32'(n_rsp), 32'd0);

`ifdef LSU_RMW_EN
    // Reset during RD_WAIT of an SH: the write phase must never appear.
    @(negedge clk);
    req_write = 1'b1; req_funct3 = 3'd1; req_addr = 32'h12; req_wdata = 32'h5555; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rmw rst strobes", {30'b0, mtrig[0], mtrig[1]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_wr = 0; n_rsp = 0;
    repeat (12) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (mwrite[i] || mtrig[i]) n_wr++;
        if (rsp_valid[i]) n_rsp++;
      end
    end
    chk("rmw rst no write", 32'(n_wr), 32'd0);
    chk("rmw rst no rsp", 32'(n_rsp), 32'd0);
    chk("rmw rst ready", {30'b0, req_ready[0], req_ready[1]}, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected bench completion");
    $fatal(1, "timeout");
  end
endmodule
